// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the RV32I pipelined core, together with the
// EX-side operand selection that feeds the ALU. Each rising edge captures the
// decoded ID fields, or a bubble when the instruction must not enter EX. The
// stored rs1/rs2 values are then resolved against the EX/MEM and MEM/WB
// results (RAW forwarding). The operand muxes then drive the ALU directly.
// A load that is still in EX while its consumer sits in ID raises a one-cycle
// stall request.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   id_*                       decoded instruction fields from ID
//   flush_i                    kill the instruction entering EX
//   exm_rd_i/we_i/data_i       EX/MEM destination, write enable, result
//   mwb_rd_i/we_i/data_i       MEM/WB destination, write enable, writeback
//   stall_o                    hold PC and IF/ID this cycle (load-use)
//   ex_*_o                     registered control for EX/MEM
//   operand1_o, operand2_o     ALU operands
//   alu_op_o                   ALU op code, passed through unchanged
//   store_data_o               forwarded rs2 value for stores
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic            id_op_a_sel_i,
    input  logic            id_op_b_sel_i,
    input  logic            id_reg_we_i,
    input  logic            id_mem_rd_i,
    input  logic            id_mem_wr_i,

    input  logic            flush_i,

    input  logic [4:0]      exm_rd_i,
    input  logic            exm_we_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic [4:0]      mwb_rd_i,
    input  logic            mwb_we_i,
    input  logic [XLEN-1:0] mwb_data_i,

    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_reg_we_o,
    output logic            ex_mem_rd_o,
    output logic            ex_mem_wr_o,
    output logic [XLEN-1:0] operand1_o,
    output logic [XLEN-1:0] operand2_o,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] store_data_o
);

    // Registered ID fields that are consumed only inside this stage.
    logic [4:0]      ex_rs1_addr;
    logic [4:0]      ex_rs2_addr;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic            ex_op_a_sel;
    logic            ex_op_b_sel;

    logic            load_use;
    logic            insert_bubble;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use: the load in EX only has its data after MEM, so a consumer in
    // ID must wait one cycle. A flush kills the consumer anyway, so it
    // suppresses the stall.
    always_comb begin
        load_use = ex_valid_o && ex_mem_rd_o && id_valid_i &&
                   (ex_rd_addr_o != 5'd0) &&
                   ((ex_rd_addr_o == id_rs1_addr_i) ||
                    (ex_rd_addr_o == id_rs2_addr_i)) &&
                   !flush_i;
    end

    assign stall_o       = load_use;
    assign insert_bubble = flush_i || load_use;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd_addr_o <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            alu_op_o     <= '0;
            ex_op_a_sel  <= 1'b0;
            ex_op_b_sel  <= 1'b0;
            ex_reg_we_o  <= 1'b0;
            ex_mem_rd_o  <= 1'b0;
            ex_mem_wr_o  <= 1'b0;
        end else if (insert_bubble) begin
            // A bubble clears every field, not just the control bits, so a
            // dead slot never forwards stale data into the ALU.
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd_addr_o <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            alu_op_o     <= '0;
            ex_op_a_sel  <= 1'b0;
            ex_op_b_sel  <= 1'b0;
            ex_reg_we_o  <= 1'b0;
            ex_mem_rd_o  <= 1'b0;
            ex_mem_wr_o  <= 1'b0;
        end else begin
            ex_valid_o   <= id_valid_i;
            ex_pc_o      <= id_pc_i;
            ex_rs1_addr  <= id_rs1_addr_i;
            ex_rs2_addr  <= id_rs2_addr_i;
            ex_rd_addr_o <= id_rd_addr_i;
            ex_rs1_data  <= id_rs1_data_i;
            ex_rs2_data  <= id_rs2_data_i;
            ex_imm       <= id_imm_i;
            alu_op_o     <= id_alu_op_i;
            ex_op_a_sel  <= id_op_a_sel_i;
            ex_op_b_sel  <= id_op_b_sel_i;
            ex_reg_we_o  <= id_reg_we_i;
            ex_mem_rd_o  <= id_mem_rd_i;
            ex_mem_wr_o  <= id_mem_wr_i;
        end
    end

    // Forwarding: EX/MEM holds the younger result, so it wins over MEM/WB.
    // x0 is excluded on both paths so it always reads its register value.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        if (exm_we_i && (exm_rd_i != 5'd0) && (exm_rd_i == ex_rs1_addr)) begin
            fwd_rs1 = exm_data_i;
        end else if (mwb_we_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == ex_rs1_addr)) begin
            fwd_rs1 = mwb_data_i;
        end
    end

    always_comb begin
        fwd_rs2 = ex_rs2_data;
        if (exm_we_i && (exm_rd_i != 5'd0) && (exm_rd_i == ex_rs2_addr)) begin
            fwd_rs2 = exm_data_i;
        end else if (mwb_we_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == ex_rs2_addr)) begin
            fwd_rs2 = mwb_data_i;
        end
    end

    assign operand1_o   = ex_op_a_sel ? ex_pc_o : fwd_rs1;
    assign operand2_o   = ex_op_b_sel ? ex_imm  : fwd_rs2;
    // Stores take rs2 even when operand2 carries the address offset.
    assign store_data_o = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Testbench for id_ex_stage. Runs directed scenarios followed by randomized
// traffic. A reference model holds the instruction slot that should sit in EX.
// It computes the expected ALU operands, forwarding result and load-use stall
// from the pipeline rules.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            id_valid_i;
    logic [XLEN-1:0] id_pc_i;
    logic [4:0]      id_rs1_addr_i;
    logic [4:0]      id_rs2_addr_i;
    logic [4:0]      id_rd_addr_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [3:0]      id_alu_op_i;
    logic            id_op_a_sel_i;
    logic            id_op_b_sel_i;
    logic            id_reg_we_i;
    logic            id_mem_rd_i;
    logic            id_mem_wr_i;
    logic            flush_i;
    logic [4:0]      exm_rd_i;
    logic            exm_we_i;
    logic [XLEN-1:0] exm_data_i;
    logic [4:0]      mwb_rd_i;
    logic            mwb_we_i;
    logic [XLEN-1:0] mwb_data_i;
    logic            stall_o;
    logic            ex_valid_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [4:0]      ex_rd_addr_o;
    logic            ex_reg_we_o;
    logic            ex_mem_rd_o;
    logic            ex_mem_wr_o;
    logic [XLEN-1:0] operand1_o;
    logic [XLEN-1:0] operand2_o;
    logic [3:0]      alu_op_o;
    logic [XLEN-1:0] store_data_o;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_valid_i    (id_valid_i),
        .id_pc_i       (id_pc_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_rs1_data_i (id_rs1_data_i),
        .id_rs2_data_i (id_rs2_data_i),
        .id_imm_i      (id_imm_i),
        .id_alu_op_i   (id_alu_op_i),
        .id_op_a_sel_i (id_op_a_sel_i),
        .id_op_b_sel_i (id_op_b_sel_i),
        .id_reg_we_i   (id_reg_we_i),
        .id_mem_rd_i   (id_mem_rd_i),
        .id_mem_wr_i   (id_mem_wr_i),
        .flush_i       (flush_i),
        .exm_rd_i      (exm_rd_i),
        .exm_we_i      (exm_we_i),
        .exm_data_i    (exm_data_i),
        .mwb_rd_i      (mwb_rd_i),
        .mwb_we_i      (mwb_we_i),
        .mwb_data_i    (mwb_data_i),
        .stall_o       (stall_o),
        .ex_valid_o    (ex_valid_o),
        .ex_pc_o       (ex_pc_o),
        .ex_rd_addr_o  (ex_rd_addr_o),
        .ex_reg_we_o   (ex_reg_we_o),
        .ex_mem_rd_o   (ex_mem_rd_o),
        .ex_mem_wr_o   (ex_mem_wr_o),
        .operand1_o    (operand1_o),
        .operand2_o    (operand2_o),
        .alu_op_o      (alu_op_o),
        .store_data_o  (store_data_o)
    );

    always #5 clk_i = ~clk_i;

    // One instruction slot as the EX stage should see it.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        asel;
        logic        bsel;
        logic        we;
        logic        mrd;
        logic        mwr;
    } slot_t;

    slot_t slot;
    int    totalCount = 0;
    int    badCount   = 0;

    // Newest matching producer wins; x0 never receives a forwarded value.
    function automatic logic [31:0] refForward(logic [4:0] rs, logic [31:0] rf);
        if (rs == 5'd0)                         return rf;
        if (exm_we_i && exm_rd_i == rs)         return exm_data_i;
        if (mwb_we_i && mwb_rd_i == rs)         return mwb_data_i;
        return rf;
    endfunction

    function automatic logic refStall();
        if (flush_i || !id_valid_i)             return 1'b0;
        if (!(slot.valid && slot.mrd))          return 1'b0;
        if (slot.rd == 5'd0)                    return 1'b0;
        return (slot.rd == id_rs1_addr_i) || (slot.rd == id_rs2_addr_i);
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) else begin
            badCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] f1;
        logic [31:0] f2;
        f1 = refForward(slot.rs1, slot.d1);
        f2 = refForward(slot.rs2, slot.d2);
        compare("stall",      {31'd0, stall_o},      {31'd0, refStall()});
        compare("ex_valid",   {31'd0, ex_valid_o},   {31'd0, slot.valid});
        compare("ex_pc",      ex_pc_o,               slot.pc);
        compare("ex_rd",      {27'd0, ex_rd_addr_o}, {27'd0, slot.rd});
        compare("ex_reg_we",  {31'd0, ex_reg_we_o},  {31'd0, slot.we});
        compare("ex_mem_rd",  {31'd0, ex_mem_rd_o},  {31'd0, slot.mrd});
        compare("ex_mem_wr",  {31'd0, ex_mem_wr_o},  {31'd0, slot.mwr});
        compare("alu_op",     {28'd0, alu_op_o},     {28'd0, slot.op});
        compare("operand1",   operand1_o,            slot.asel ? slot.pc : f1);
        compare("operand2",   operand2_o,            slot.bsel ? slot.imm : f2);
        compare("store_data", store_data_o,          f2);
    endtask

    // Called just after a falling edge with inputs already set: check the
    // current cycle, then advance the model across the rising edge.
    task automatic applyStimulus();
        slot_t nxt;
        #1;
        checkOutput();
        if (flush_i || refStall()) begin
            nxt = '{default: '0};
        end else begin
            nxt = '{valid: id_valid_i, pc: id_pc_i, rs1: id_rs1_addr_i, rs2: id_rs2_addr_i,
                    rd: id_rd_addr_i, d1: id_rs1_data_i, d2: id_rs2_data_i, imm: id_imm_i,
                    op: id_alu_op_i, asel: id_op_a_sel_i, bsel: id_op_b_sel_i,
                    we: id_reg_we_i, mrd: id_mem_rd_i, mwr: id_mem_wr_i};
        end
        @(posedge clk_i);
        slot = nxt;
        @(negedge clk_i);
    endtask

    task automatic setId(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] op,
                         input logic asel, input logic bsel, input logic we,
                         input logic mrd, input logic mwr);
        id_valid_i = v;    id_pc_i = pc;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_rs1_data_i = d1;  id_rs2_data_i = d2;  id_imm_i = imm;
        id_alu_op_i = op;  id_op_a_sel_i = asel; id_op_b_sel_i = bsel;
        id_reg_we_i = we;  id_mem_rd_i = mrd;   id_mem_wr_i = mwr;
    endtask

    task automatic setFwd(input logic [4:0] erd, input logic ewe, input logic [31:0] edata,
                          input logic [4:0] mrd, input logic mwe, input logic [31:0] mdata);
        exm_rd_i = erd; exm_we_i = ewe; exm_data_i = edata;
        mwb_rd_i = mrd; mwb_we_i = mwe; mwb_data_i = mdata;
    endtask

    initial begin
        logic [4:0] r1;
        logic [4:0] r2;

        slot    = '{default: '0};
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setFwd(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput();
        rst_ni = 1'b1;

        // EX/MEM forward onto rs1.
        setId(1, 32'h40, 5, 6, 9, 0, 32'h11, 0, 4'd0, 0, 0, 1, 0, 0);
        applyStimulus();
        setFwd(5, 1, 32'h1234_5678, 0, 0, 0);
        applyStimulus();

        // Both producers target x5: EX/MEM must win.
        setFwd(5, 1, 32'hAAAA_AAAA, 5, 1, 32'h5555_5555);
        setId(1, 32'h44, 0, 0, 9, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0);
        applyStimulus();
        // rs1 = x0 with producers aimed at x0: no forward.
        setFwd(0, 1, 32'hAAAA_AAAA, 0, 1, 32'h5555_5555);
        applyStimulus();
        // MEM/WB only.
        setId(1, 32'h48, 5, 5, 9, 32'h77, 32'h88, 0, 4'd1, 0, 0, 1, 0, 0);
        setFwd(3, 1, 32'hAAAA_AAAA, 5, 1, 32'h5555_5555);
        applyStimulus();
        applyStimulus();
        setFwd(0, 0, 0, 0, 0, 0);

        // Load-use: LW x7 then ADD x8,x7,x1.
        setId(1, 32'h50, 1, 0, 7, 32'h100, 0, 32'h4, 4'd0, 0, 1, 1, 1, 0);
        applyStimulus();
        setId(1, 32'h54, 7, 1, 8, 32'h0, 32'h100, 0, 4'd0, 0, 0, 1, 0, 0);
        applyStimulus();
        applyStimulus();
        applyStimulus();

        // Load-use together with flush: flush wins.
        setId(1, 32'h60, 1, 0, 7, 32'h100, 0, 32'h8, 4'd0, 0, 1, 1, 1, 0);
        applyStimulus();
        setId(1, 32'h64, 2, 7, 8, 32'h5, 32'h0, 0, 4'd0, 0, 0, 1, 0, 0);
        flush_i = 1'b1;
        applyStimulus();
        flush_i = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();

        // LUI then AUIPC.
        setId(1, 32'h70, 0, 0, 3, 0, 0, 32'hABCD_E000, 4'd10, 0, 1, 1, 0, 0);
        applyStimulus();
        setId(1, 32'h100, 0, 0, 4, 0, 0, 32'h0000_1000, 4'd0, 1, 1, 1, 0, 0);
        applyStimulus();
        // Store with immediate offset: store_data follows rs2 forward.
        setId(1, 32'h104, 2, 9, 0, 32'h200, 32'h33, 32'h10, 4'd0, 0, 1, 0, 0, 1);
        applyStimulus();
        setFwd(9, 1, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus();

        // Reset mid-operation discards the in-flight instruction.
        setFwd(0, 0, 0, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        slot   = '{default: '0};
        #1;
        checkOutput();
        @(negedge clk_i);
        rst_ni = 1'b1;
        setId(1, 32'h200, 3, 4, 5, 32'h1, 32'h2, 0, 4'd5, 0, 0, 1, 0, 0);
        applyStimulus();
        applyStimulus();

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            setId(1'($urandom_range(0, 3) != 0), $urandom, r1, r2, 5'($urandom_range(0, 7)),
                  (r1 == 0) ? 32'd0 : $urandom, (r2 == 0) ? 32'd0 : $urandom, $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            setFwd(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            flush_i = ($urandom_range(0, 7) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register plus EX-side operand selection for the RV32I pipelined core. It sits directly upstream of the ALU and registers the decoded instruction fields on each clock. It then resolves the ALU operands using RAW forwarding from the EX/MEM and MEM/WB stages and drives `operand1_i`, `operand2_i` and `alu_op_i` on the ALU. It also detects load-use hazards, requests a one-cycle stall, and inserts bubbles on flush.

## Interface
- `XLEN`, 32, datapath width
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `id_valid_i`  in  1  ID holds a valid instruction
- `id_pc_i`  in  XLEN  instruction PC
- `id_rs1_addr_i`, `id_rs2_addr_i`, `id_rd_addr_i`  in  5  register indices
- `id_rs1_data_i`, `id_rs2_data_i`  in  XLEN  register-file read data
- `id_imm_i`  in  XLEN  sign-extended immediate; U-type is already placed in bits [31:12]
- `id_alu_op_i`  in  4  ALU op code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI
- `id_op_a_sel_i`  in  1  operand 1 source: 0 = rs1, 1 = PC
- `id_op_b_sel_i`  in  1  operand 2 source: 0 = rs2, 1 = imm
- `id_reg_we_i`, `id_mem_rd_i`, `id_mem_wr_i`  in  1  control bits
- `flush_i`  in  1  kill the instruction entering EX (taken branch or jump)
- `exm_rd_i`, `exm_we_i`, `exm_data_i`  in  5/1/XLEN  EX/MEM destination, write enable and result
- `mwb_rd_i`, `mwb_we_i`, `mwb_data_i`  in  5/1/XLEN  MEM/WB destination, write enable and writeback value
- `stall_o`  out  1  hold PC and IF/ID this cycle
- `ex_valid_o`, `ex_pc_o`, `ex_rd_addr_o`, `ex_reg_we_o`, `ex_mem_rd_o`, `ex_mem_wr_o`  out  various  registered control passed to EX/MEM
- `operand1_o`, `operand2_o`  out  XLEN  connect to ALU `operand1_i` and `operand2_i`
- `alu_op_o`  out  4  connect to ALU `alu_op_i`
- `store_data_o`  out  XLEN  forwarded rs2 value, used for stores

## Operation
- **Register.** On each rising edge, all `id_*` fields are captured into the ex_* registers.
- **Bubble.** When `flush_i` is set or `stall_o` is set, a bubble is captured instead of the ID fields:
  - valid, reg_we, mem_rd, mem_wr = 0
  - alu_op = 0; the remaining fields are don't-care but are held at 0
- **Load-use detection** (combinational), `stall_o` = 1 when all of the following hold:
  - `ex_valid_o` & `ex_mem_rd_o` & `id_valid_i` & (`ex_rd_addr_o` != 0)
  - `ex_rd_addr_o` equals `id_rs1_addr_i`, or it equals `id_rs2_addr_i`
  - `flush_i` = 0
- **Forwarding**, evaluated per source (rs1, rs2) using the registered `ex_rs*_addr`:
  - Priority 1: EX/MEM, when `exm_we_i` & (`exm_rd_i` != 0) & (`exm_rd_i` == rs) → `exm_data_i`.
  - Priority 2: MEM/WB, when `mwb_we_i` & (`mwb_rd_i` != 0) & (`mwb_rd_i` == rs) → `mwb_data_i`.
  - Otherwise, the registered register-file data.
  - Register x0 is never forwarded and always reads as the registered value, which is 0.
- **Operand muxes:**
  - `operand1_o` = op_a_sel ? ex_pc : fwd_rs1
  - `operand2_o` = op_b_sel ? ex_imm : fwd_rs2
  - `store_data_o` = fwd_rs2, regardless of op_b_sel
- **Op code.** `alu_op_o` is passed through from the register unchanged. Codes 11–15 are never generated by decode and are passed through unmodified.

## Timing
- **Reset.** `rst_ni` low asynchronously clears every register to 0. As a result:
  - `ex_valid_o`, `ex_reg_we_o`, `ex_mem_rd_o`, `ex_mem_wr_o` = 0
  - `alu_op_o` = 0 and `ex_pc_o` = 0
  - `operand1_o` and `operand2_o` = 0 while the forward inputs are idle
- **Reset mid-operation.** The in-flight instruction is discarded; no partial state survives.
- **Latency.** One cycle from the ID inputs to the ex_* registers. Operands are combinational from the register and forward inputs within the same cycle, so there is zero added latency into the ALU.
- **Stall.** Lasts exactly one cycle per load-use hazard: the next cycle holds a bubble, so the load has moved to EX/MEM and is no longer in ID/EX.
- **Stall and flush together.** Flush takes precedence: the bubble is inserted and `stall_o` = 0.
- **Independence.** A load-use on rs1 and rs2 at the same time still produces a single one-cycle stall.

## Test plan
- **Reset.** Assert `rst_ni`=0 mid-stream, then release → all outputs are 0 and the first edge after release captures normally.
- **EX/MEM forward.** ADD with rs1=x5 and `exm_rd_i`=5, `exm_we_i`=1, `exm_data_i`=0x1234_5678, register-file data 0 → `operand1_o`=0x1234_5678.
- **Forward priority.** EX/MEM and MEM/WB both target x5, with 0xAAAA_AAAA and 0x5555_5555 respectively → `operand1_o`=0xAAAA_AAAA. The same setup with rd=x0 → no forward; the register-file value is used.
- **Load-use.** Cycle N: LW x7 is in EX; ID holds ADD x8,x7,x1 → `stall_o`=1 in cycle N. Cycle N+1: `ex_valid_o`=0 and `stall_o`=0.
- **Flush over stall.** Load-use condition together with `flush_i`=1 → `stall_o`=0 and a bubble is captured.
- **Immediate/PC paths.** LUI with imm=0xABCDE000, op_b_sel=1 → `operand2_o`=0xABCDE000 and `alu_op_o`=10. AUIPC with pc=0x100, op_a_sel=1 → `operand1_o`=0x100.
